// File: rtl/mdu_pipe.sv
// mdu_pipe -- iterative multiply/divide unit with HI/LO registers for the
// 5-stage MIPS datapath.
//
// An op is accepted from EX, run as WIDTH radix-2 steps (shift-add multiply,
// restoring divide) and then sign-corrected. The signed result is written
// to HI/LO on the FIX edge. While an op is in flight, any ID-stage
// instruction that touches the MDU or HI/LO is stalled through stall_mdu.
//
// Optional build macro: MDU_EARLY_OUT_EN
//   When defined, a multiply finishes early once the remaining multiplier
//   bits are all zero. Results are identical in both builds; only the
//   busy/done timing changes.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous reset, active low
//   start_e    EX-stage MDU op valid
//   op_e       00 mult, 01 multu, 10 div, 11 divu
//   srca_e     rs operand (multiplicand / dividend), post-forwarding
//   srcb_e     rt operand (multiplier / divisor), post-forwarding
//   kill_e     abort in-flight op (EX flush)
//   mdu_use_d  ID-stage instr is mult/div/mfhi/mflo/mthi/mtlo
//   mthi_w     WB-stage write of wdata_w to HI
//   mtlo_w     WB-stage write of wdata_w to LO
//   wdata_w    mthi/mtlo data
//   busy       operation in flight
//   done       one-cycle pulse after HI/LO are written by an op
//   stall_mdu  busy & mdu_use_d (combinational)
//   hi, lo     HI / LO registers
module mdu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_e,
  input  logic [1:0]       op_e,
  input  logic [WIDTH-1:0] srca_e,
  input  logic [WIDTH-1:0] srcb_e,
  input  logic             kill_e,
  input  logic             mdu_use_d,
  input  logic             mthi_w,
  input  logic             mtlo_w,
  input  logic [WIDTH-1:0] wdata_w,
  output logic             busy,
  output logic             done,
  output logic             stall_mdu,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;

  // acc_hi/acc_lo: product {hi,lo} for multiply, {remainder,quotient} for
  // divide. opnd_b is the multiplicand or the divisor.
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   opnd_b;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;

  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  logic               accept;
  logic               op_signed;
  logic               op_div;
  logic               div_zero;
  logic               use_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem_next;
  logic [WIDTH-1:0]   div_quo_next;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  logic               early_out;

`ifdef MDU_EARLY_OUT_EN
  // Shadow of the not-yet-consumed multiplier bits; zero means every
  // remaining step would only shift, so the shift is done in one go.
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   eo_shift;
  logic [2*WIDTH-1:0] eo_prod;

  assign early_out = ~is_div & (mplier == '0);
  assign eo_shift  = CNT_W'(WIDTH) - cnt;
  assign eo_prod   = {acc_hi, acc_lo} >> eo_shift;
`else
  assign early_out = 1'b0;
`endif

  // Operand conditioning at accept time. A divide by zero is run as an
  // unsigned divide, which naturally leaves the raw dividend in the
  // remainder and all ones in the quotient.
  assign accept     = (state == IDLE) & start_e & ~kill_e;
  assign op_signed  = ~op_e[0];
  assign op_div     = op_e[1];
  assign div_zero   = op_div & (srcb_e == '0);
  assign use_signed = op_signed & ~div_zero;
  assign a_neg      = use_signed & srca_e[WIDTH-1];
  assign b_neg      = use_signed & srcb_e[WIDTH-1];
  assign a_abs      = a_neg ? (~srca_e + WIDTH'(1)) : srca_e;
  assign b_abs      = b_neg ? (~srcb_e + WIDTH'(1)) : srcb_e;

  // One shift-add multiply step: the multiplier sits in acc_lo and is
  // consumed from bit 0 while product bits shift in from the top.
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_lo[WIDTH-1:1]};

  // One restoring divide step. The shifted remainder is WIDTH+1 bits for the
  // compare; when it is >= divisor the true difference fits in WIDTH bits.
  assign div_shift    = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge       = div_shift >= {1'b0, opnd_b};
  assign div_sub      = div_shift[WIDTH-1:0] - opnd_b;
  assign div_rem_next = div_ge ? div_sub : div_shift[WIDTH-1:0];
  assign div_quo_next = {acc_lo[WIDTH-2:0], div_ge};

  // Sign correction applied on the FIX edge.
  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_q ? (~prod + (2*WIDTH)'(1)) : prod;
  assign quo_fix  = neg_q ? (~acc_lo + WIDTH'(1)) : acc_lo;
  assign rem_fix  = neg_r ? (~acc_hi + WIDTH'(1)) : acc_hi;
  assign res_hi   = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo   = is_div ? quo_fix : prod_fix[WIDTH-1:0];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A kill returns to IDLE from any state.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start_e) next_state = RUN;
      RUN:  if (early_out || (cnt == LAST_STEP)) next_state = FIX;
      FIX:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (kill_e) next_state = IDLE;
  end

  // FSM outputs.
  always_comb begin
    busy = (state != IDLE);
  end

  assign stall_mdu = busy & mdu_use_d;
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

  // Iteration datapath: load on accept, one step per RUN edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd_b <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`ifdef MDU_EARLY_OUT_EN
      mplier <= '0;
`endif
    end else if (accept) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= op_div ? a_abs : b_abs;
      opnd_b <= op_div ? b_abs : a_abs;
      is_div <= op_div;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= op_div & a_neg;
`ifdef MDU_EARLY_OUT_EN
      mplier <= b_abs;
`endif
    end else if ((state == RUN) && !kill_e) begin
      cnt <= cnt + CNT_W'(1);
`ifdef MDU_EARLY_OUT_EN
      mplier <= mplier >> 1;
      if (early_out) begin
        {acc_hi, acc_lo} <= eo_prod;
      end else
`endif
      if (is_div) begin
        acc_hi <= div_rem_next;
        acc_lo <= div_quo_next;
      end else begin
        {acc_hi, acc_lo} <= mul_next;
      end
    end
  end

  // HI/LO: op result on the FIX edge, otherwise mthi/mtlo writes. Writes
  // during RUN land now and are overwritten by the result later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state == FIX) begin
      if (!kill_e) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end else begin
      if (mthi_w) hi_q <= wdata_w;
      if (mtlo_w) lo_q <= wdata_w;
    end
  end

  // done pulses for the cycle after a completed FIX edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state == FIX) && !kill_e;
    end
  end

endmodule

// File: tb/tb_mdu_pipe.sv
// tb_mdu_pipe -- directed self-checking bench for mdu_pipe (WIDTH=32).
// Inputs are driven on the falling edge and outputs sampled on the falling
// edge, half a cycle away from the active rising edge.
module tb_mdu_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_e;
  logic [1:0]  op_e;
  logic [31:0] srca_e;
  logic [31:0] srcb_e;
  logic        kill_e;
  logic        mdu_use_d;
  logic        mthi_w;
  logic        mtlo_w;
  logic [31:0] wdata_w;
  logic        busy;
  logic        done;
  logic        stall_mdu;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests_run = 0;
  int fails     = 0;

`ifdef MDU_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  mdu_pipe #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start_e   (start_e),
    .op_e      (op_e),
    .srca_e    (srca_e),
    .srcb_e    (srcb_e),
    .kill_e    (kill_e),
    .mdu_use_d (mdu_use_d),
    .mthi_w    (mthi_w),
    .mtlo_w    (mtlo_w),
    .wdata_w   (wdata_w),
    .busy      (busy),
    .done      (done),
    .stall_mdu (stall_mdu),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  // The hazard unit must never present a new op while one is in flight.
  always @(posedge clk) begin
    if (reset === 1'b1 && start_e === 1'b1 && busy === 1'b1) begin
      fails++;
      $error("[TB] FAIL start_while_busy: observed start_e=1 with busy=1, expected no overlap");
    end
  end

  // Expected busy cycles of a multiply given the absolute multiplier.
  function automatic int mul_busy(input logic [31:0] mplier_abs);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) if (mplier_abs[i]) n = i + 1;
    return EARLY ? (n + 2) : 33;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Presents one op for a single edge, then counts busy cycles (bounded)
  // and returns the done level seen on the first non-busy cycle.
  task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, output int cyc,
                                output logic done_seen);
    @(negedge clk);
    start_e = 1'b1;
    op_e    = op;
    srca_e  = a;
    srcb_e  = b;
    @(negedge clk);
    start_e = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    done_seen = done;
  endtask

  int          cyc;
  logic        dseen;
  int          stall_cnt;
  logic        any_done;
  logic [31:0] lo_before;

  initial begin
    reset     = 1'b0;
    start_e   = 1'b0;
    op_e      = 2'b00;
    srca_e    = '0;
    srcb_e    = '0;
    kill_e    = 1'b0;
    mdu_use_d = 1'b0;
    mthi_w    = 1'b0;
    mtlo_w    = 1'b0;
    wdata_w   = '0;

    // Reset state
    #12;
    check_output("rst_hi", hi, 32'h0);
    check_output("rst_lo", lo, 32'h0);
    check_output("rst_busy", {31'b0, busy}, 32'h0);
    check_output("rst_done", {31'b0, done}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // mult -3 * 5 = -15
    apply_stimulus(OP_MULT, 32'hFFFFFFFD, 32'h00000005, cyc, dseen);
    check_output("mult_busy", cyc, mul_busy(32'd5));
    check_output("mult_done", {31'b0, dseen}, 32'h1);
    check_output("mult_hi", hi, 32'hFFFFFFFF);
    check_output("mult_lo", lo, 32'hFFFFFFF1);
    @(negedge clk);
    check_output("mult_done_drop", {31'b0, done}, 32'h0);

    // multu FFFFFFFF * 2
    apply_stimulus(OP_MULTU, 32'hFFFFFFFF, 32'h00000002, cyc, dseen);
    check_output("multu_hi", hi, 32'h00000001);
    check_output("multu_lo", lo, 32'hFFFFFFFE);

    // mult -1 * 2
    apply_stimulus(OP_MULT, 32'hFFFFFFFF, 32'h00000002, cyc, dseen);
    check_output("mult_m1_hi", hi, 32'hFFFFFFFF);
    check_output("mult_m1_lo", lo, 32'hFFFFFFFE);

    // div -7 / 2 -> q=-3, r=-1
    apply_stimulus(OP_DIV, 32'hFFFFFFF9, 32'h00000002, cyc, dseen);
    check_output("div_busy", cyc, 32'd33);
    check_output("div_done", {31'b0, dseen}, 32'h1);
    check_output("div_lo", lo, 32'hFFFFFFFD);
    check_output("div_hi", hi, 32'hFFFFFFFF);

    // div 7 / -2 -> q=-3, r=1
    apply_stimulus(OP_DIV, 32'h00000007, 32'hFFFFFFFE, cyc, dseen);
    check_output("div_negb_lo", lo, 32'hFFFFFFFD);
    check_output("div_negb_hi", hi, 32'h00000001);

    // divu 10 / 0
    apply_stimulus(OP_DIVU, 32'h0000000A, 32'h00000000, cyc, dseen);
    check_output("divu0_busy", cyc, 32'd33);
    check_output("divu0_hi", hi, 32'h0000000A);
    check_output("divu0_lo", lo, 32'hFFFFFFFF);

    // signed div of a negative dividend by 0
    apply_stimulus(OP_DIV, 32'hFFFFFFF0, 32'h00000000, cyc, dseen);
    check_output("div0_neg_hi", hi, 32'hFFFFFFF0);
    check_output("div0_neg_lo", lo, 32'hFFFFFFFF);

    // most-negative / -1
    apply_stimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF, cyc, dseen);
    check_output("div_ovf_busy", cyc, 32'd33);
    check_output("div_ovf_lo", lo, 32'h80000000);
    check_output("div_ovf_hi", hi, 32'h00000000);

    // mult 7 * 3 (early-out candidate)
    apply_stimulus(OP_MULT, 32'h00000007, 32'h00000003, cyc, dseen);
    check_output("mult73_busy", cyc, mul_busy(32'd3));
    check_output("mult73_lo", lo, 32'h00000015);
    check_output("mult73_hi", hi, 32'h00000000);

    // Stall window: mdu_use_d held while a mult runs
    @(negedge clk);
    mdu_use_d = 1'b1;
    start_e   = 1'b1;
    op_e      = OP_MULT;
    srca_e    = 32'd6;
    srcb_e    = 32'd7;
    check_output("stall_pre", {31'b0, stall_mdu}, 32'h0);
    @(negedge clk);
    start_e   = 1'b0;
    stall_cnt = 0;
    any_done  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (stall_mdu === 1'b1) stall_cnt++;
      if (done === 1'b1) any_done = 1'b1;
      @(negedge clk);
    end
    check_output("stall_cycles", stall_cnt, mul_busy(32'd7));
    check_output("stall_after", {31'b0, stall_mdu}, 32'h0);
    check_output("stall_done_seen", {31'b0, any_done}, 32'h1);
    check_output("stall_lo", lo, 32'd42);
    mdu_use_d = 1'b0;

    // mthi, then kill a divu at RUN cycle 10
    lo_before = 32'd42;
    @(negedge clk);
    mthi_w  = 1'b1;
    wdata_w = 32'h12345678;
    @(negedge clk);
    mthi_w  = 1'b0;
    check_output("mthi_hi", hi, 32'h12345678);
    start_e = 1'b1;
    op_e    = OP_DIVU;
    srca_e  = 32'd9;
    srcb_e  = 32'd4;
    @(negedge clk);
    start_e = 1'b0;
    repeat (9) @(negedge clk);
    check_output("kill_busy_before", {31'b0, busy}, 32'h1);
    kill_e = 1'b1;
    @(negedge clk);
    kill_e = 1'b0;
    check_output("kill_busy", {31'b0, busy}, 32'h0);
    any_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) any_done = 1'b1;
      @(negedge clk);
    end
    check_output("kill_no_done", {31'b0, any_done}, 32'h0);
    check_output("kill_hi", hi, 32'h12345678);
    check_output("kill_lo", lo, lo_before);

    // Reset mid-RUN
    @(negedge clk);
    start_e = 1'b1;
    op_e    = OP_DIVU;
    srca_e  = 32'd9;
    srcb_e  = 32'd4;
    @(negedge clk);
    start_e = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("rstrun_busy", {31'b0, busy}, 32'h0);
    check_output("rstrun_hi", hi, 32'h0);
    check_output("rstrun_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // divu 9 / 4 completes normally after reset
    apply_stimulus(OP_DIVU, 32'd9, 32'd4, cyc, dseen);
    check_output("divu94_hi", hi, 32'd1);
    check_output("divu94_lo", lo, 32'd2);

    // start and kill on the same edge: op not accepted
    @(negedge clk);
    start_e = 1'b1;
    kill_e  = 1'b1;
    op_e    = OP_MULT;
    srca_e  = 32'd3;
    srcb_e  = 32'd3;
    @(negedge clk);
    start_e = 1'b0;
    kill_e  = 1'b0;
    check_output("startkill_busy", {31'b0, busy}, 32'h0);

    // mthi on the accept edge and mtlo during RUN, both overwritten
    @(negedge clk);
    start_e = 1'b1;
    op_e    = OP_MULTU;
    srca_e  = 32'd3;
    srcb_e  = 32'd4;
    mthi_w  = 1'b1;
    wdata_w = 32'hABCD0000;
    @(negedge clk);
    start_e = 1'b0;
    mthi_w  = 1'b0;
    check_output("mt_start_hi", hi, 32'hABCD0000);
    mtlo_w  = 1'b1;
    wdata_w = 32'd55;
    @(negedge clk);
    mtlo_w  = 1'b0;
    check_output("mt_run_lo", lo, 32'd55);
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check_output("mt_over_busy_bound", {31'b0, busy}, 32'h0);
    check_output("mt_over_hi", hi, 32'h0);
    check_output("mt_over_lo", lo, 32'd12);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/mdu_pipe.md
Name: mdu_pipe

Overview:
- Parametrised iterative multiply/divide unit with HI/LO registers for the 5-stage pipelined MIPS datapath.
- Operands and op arrive from the EX stage; results are read by mfhi/mflo through the hi/lo outputs.
- Raises a stall request to the hazard unit while an ID-stage instruction needs HI/LO or the MDU during an operation.
- Adds mult/multu/div/divu/mthi/mtlo support that the current datapath lacks.

Parameters:
WIDTH, 32, operand and HI/LO width (>= 4, even)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start_e  in  1  EX-stage MDU op valid
op_e  in  2  00 mult, 01 multu, 10 div, 11 divu
srca_e  in  WIDTH  rs operand (multiplicand / dividend), post-forwarding
srcb_e  in  WIDTH  rt operand (multiplier / divisor), post-forwarding
kill_e  in  1  abort in-flight op (flush_e from hazard unit)
mdu_use_d  in  1  ID-stage instr is mult/div/mfhi/mflo/mthi/mtlo
mthi_w  in  1  WB-stage write of wdata_w to HI
mtlo_w  in  1  WB-stage write of wdata_w to LO
wdata_w  in  WIDTH  mthi/mtlo data
busy  out  1  operation in flight
done  out  1  one-cycle pulse when HI/LO are updated by an op
stall_mdu  out  1  busy & mdu_use_d, combinational
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (reset=0, async): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset mid-operation discards the op.
- States: IDLE, RUN, FIX. busy=1 in RUN and FIX.
- IDLE: start_e=1 and kill_e=0 at edge 0 -> latch absolute values of operands (signed ops) or raw values (unsigned ops), latch result sign flags, go to RUN, counter=0.
- RUN: one radix-2 step per edge (shift-add multiply, restoring divide). After WIDTH steps -> FIX.
- FIX: apply sign correction, then write HI/LO and go to IDLE.
  - Multiply: {hi,lo} = 2*WIDTH-bit product.
  - Divide: lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend.
- done=1 for exactly the cycle after the FIX edge.
- Latency: start at edge 0 gives results visible after edge WIDTH+1. busy is high for WIDTH+1 cycles (33 for WIDTH=32).
- Divide by zero: no trap. Result is hi=dividend (original, unsigned view) and lo=all ones. Takes the full latency.
- Signed div of most-negative value by -1: lo=most-negative, hi=0, with no special-case cycle.
- start_e while busy: ignored. The hazard unit guarantees this through stall_mdu. Bench asserts it never occurs.
- kill_e=1 in any state: return to IDLE on the next edge with hi/lo unchanged and no done pulse. kill_e at the same edge as start_e: the op is not accepted.
- mthi_w/mtlo_w: write on the edge when in IDLE or in RUN (RUN-state writes are later overwritten by the result). Writes are ignored in FIX.
- mthi_w/mtlo_w on the same edge as start_e acceptance: the write takes effect, and the op result later overwrites it.
- hi/lo change only on reset, mt writes, or the FIX edge.

Optional Feature:
MDU_EARLY_OUT_EN
- Defined: during a multiply in RUN, if all remaining unprocessed multiplier bits are zero, skip the remaining steps.
  - Shift the partial product by the remaining count in one step and go to FIX.
  - Multiply by 0 completes in 2 cycles of busy.
  - Divide latency is unchanged.
- Undefined: fixed WIDTH+1 busy cycles for every op. Results are identical in both builds; only the timing of busy/done differs.

Test Plan:
- mult, srca=FFFFFFFD (-3), srcb=00000005 -> after 33 busy cycles, done pulse; hi=FFFFFFFF, lo=FFFFFFF1.
- multu, srca=FFFFFFFF, srcb=00000002 -> hi=00000001, lo=FFFFFFFE; signed mult of the same operands -> hi=FFFFFFFF, lo=FFFFFFFE.
- div, srca=FFFFFFF9 (-7), srcb=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; divu 0000000A by 0 -> hi=0000000A, lo=FFFFFFFF.
- Start mult, hold mdu_use_d=1 for 40 cycles -> stall_mdu=1 for exactly 33 cycles, then 0 once done pulses.
- mthi 12345678, then divu 9/4 with kill_e at RUN cycle 10 -> no done, busy drops next edge, hi=12345678. Repeat with reset=0 mid-RUN -> hi=lo=0, busy=0.
- With MDU_EARLY_OUT_EN: mult 7 by 3 -> lo=00000015, hi=0, busy < 33 cycles; without it, busy=33.
